// File: rtl/encoder_pkg.sv
// encoder_pkg: shared step encoding, Gray forward sequence and default widths for the encoder front end
package encoder_pkg;
  typedef enum logic [1:0] {STEP_NONE, STEP_FWD, STEP_REV, STEP_ERR} step_t;
  localparam logic [1:0] GRAY_NEXT_00 = 2'b01;
  localparam logic [1:0] GRAY_NEXT_01 = 2'b11;
  localparam logic [1:0] GRAY_NEXT_11 = 2'b10;
  localparam logic [1:0] GRAY_NEXT_10 = 2'b00;
  localparam int DEFAULT_POS_W = 32;
  function automatic logic [1:0] gray_fwd(input logic [1:0] s);
    return s == 2'b00 ? GRAY_NEXT_00 : s == 2'b01 ? GRAY_NEXT_01 : s == 2'b11 ? GRAY_NEXT_11 : GRAY_NEXT_10;
  endfunction
  function automatic step_t decode(input logic [1:0] prev, input logic [1:0] cur);
    return cur == prev ? STEP_NONE : cur == gray_fwd(prev) ? STEP_FWD : prev == gray_fwd(cur) ? STEP_REV : STEP_ERR;
  endfunction
endpackage

// File: rtl/quad_input_filter.sv
// quad_input_filter: two-flop synchronizer plus run-length glitch filter for one encoder channel
module quad_input_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic din,
  output logic dout
);
  localparam int CW = FILTER_LEN > 0 ? $clog2(FILTER_LEN + 1) : 1;
  logic s1, s2;
  logic [CW-1:0] cnt;
  // a change is accepted on the (FILTER_LEN+1)th consecutive differing cycle, so F=0 is a plain register
  always_ff @(posedge clk)
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      dout <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (load) begin
        dout <= s2;
        cnt <= '0;
      end else if (s2 == dout) cnt <= '0;
      else if (cnt == CW'(FILTER_LEN)) begin
        dout <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/quad_encoder_trigger.sv
// quad_encoder_trigger: quadrature decode, signed position and backlash-aware pitch trigger generation
module quad_encoder_trigger
  import encoder_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int POS_W = DEFAULT_POS_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             enable,
  input  logic [POS_W-1:0] N_encoder,
  output logic             encoder_trigger,
  output logic [POS_W-1:0] position,
  output logic             dir,
  output logic             quad_error,
  output logic [POS_W-1:0] trigger_count
);
  logic [1:0] arm_cnt, prev;
  logic armed, load, fa, fb, wrap;
  logic [POS_W-1:0] acc, debt;
  step_t step;
  assign load = arm_cnt == 2'd2;
  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (.clk(clk), .reset(reset), .load(load), .din(enc_a), .dout(fa));
  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (.clk(clk), .reset(reset), .load(load), .din(enc_b), .dout(fb));
  always_comb begin
    step = armed ? decode(prev, {fa, fb}) : STEP_NONE;
    wrap = acc >= N_encoder - POS_W'(1);
  end
  // prev tracks the filtered state every cycle, so the freshly loaded state becomes the baseline before decoding arms
  always_ff @(posedge clk)
    if (reset) begin
      arm_cnt <= 2'd0;
      armed <= 1'b0;
      prev <= 2'b00;
      acc <= '0;
      debt <= '0;
      encoder_trigger <= 1'b0;
      position <= '0;
      dir <= 1'b0;
      quad_error <= 1'b0;
      trigger_count <= '0;
    end else begin
      arm_cnt <= arm_cnt == 2'd3 ? arm_cnt : arm_cnt + 2'd1;
      armed <= arm_cnt == 2'd3;
      prev <= {fa, fb};
      encoder_trigger <= 1'b0;
      if (step == STEP_FWD) begin
        position <= position + POS_W'(1);
        dir <= 1'b1;
      end
      if (step == STEP_REV) begin
        position <= position - POS_W'(1);
        dir <= 1'b0;
      end
      if (step == STEP_ERR) quad_error <= 1'b1;
      if (N_encoder != '0) begin
        if (step == STEP_REV && debt != '1) debt <= debt + POS_W'(1);
        if (step == STEP_FWD) begin
          if (debt != '0) debt <= debt - POS_W'(1);
          else if (wrap) begin
            acc <= '0;
            encoder_trigger <= enable;
            trigger_count <= trigger_count + POS_W'(enable);
          end else acc <= acc + POS_W'(1);
        end
      end
    end
endmodule

// File: doc/quad_encoder_trigger.md
# quad_encoder_trigger

Front end of the scan trigger chain: synchronizes and glitch-filters the motion stage's quadrature encoder lines, tracks signed position, and emits a one-cycle `encoder_trigger` every `N_encoder` net forward counts. Its `encoder_trigger` drives the `control` block's encoder input, which in turn sequences `laser_trigger` and `digitizer_trigger`. Reverse motion is accumulated as backlash debt, so triggers resume only at the same physical pitch.

## Interface
- `FILTER_LEN`, default 4: consecutive stable cycles required before a synchronized input change is accepted; 0 = bypass.
- `POS_W`, default 32: width of position and counters.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enc_a`  in  1  quadrature channel A, asynchronous.
- `enc_b`  in  1  quadrature channel B, asynchronous.
- `enable`  in  1  trigger pulses allowed when high.
- `N_encoder`  in  POS_W  forward counts per trigger; 0 = no triggers.
- `encoder_trigger`  out  1  one-cycle pulse per pitch.
- `position`  out  POS_W  signed position, two's complement.
- `dir`  out  1  direction of last valid step: 1 = forward.
- `quad_error`  out  1  sticky illegal-transition flag.
- `trigger_count`  out  POS_W  pulses emitted since reset; wraps.

## Operation
- Sync: two flops per channel. Filter: the filtered value takes a new synced value only after it has differed from the current filtered value for FILTER_LEN consecutive identical cycles. Any bounce restarts the run counter.
- Decode of {A,B}:
  - Forward (+1) sequence: 00→01→11→10→00. The reverse sequence is −1.
  - No change: no step.
  - Both bits change: step ERR. Sets `quad_error` until reset; `position` unchanged; the new state becomes the baseline.
- Position: +1/−1 per step, wraps modulo 2^POS_W. `dir` updates on every valid step.
- Pitch logic uses unsigned `acc` (0..N−1) and unsigned `debt`:
  - Reverse step: `debt`+1, saturating at all-ones. `acc` unchanged.
  - Forward step with `debt`>0: `debt`−1.
  - Forward step with `debt`=0 and `acc` ≥ N_encoder−1: `acc`←0, pulse. The ≥ comparison covers `N_encoder` shrinking mid-run.
  - Any other forward step: `acc`+1.
  - `N_encoder`=0: `acc` and `debt` frozen, no pulses. `N_encoder`=1: pulse on every debt-free forward step.
- `enable` low: `acc` and `debt` still update; pulse suppressed; `trigger_count` not incremented.
- Reset: all outputs 0, `acc`=`debt`=0, filter counters 0. The decoder is unarmed for the first 3 cycles after reset deasserts. On the 3rd cycle the synced values are loaded directly as filtered state and baseline, with no step generated.
- Reset asserted mid-operation overrides everything in that cycle; a pending pulse is dropped.

## Timing
- With FILTER_LEN=0, an input edge sampled at clock edge k produces registered outputs (`position`, `dir`, `encoder_trigger`) at edge k+3.
- FILTER_LEN=F adds exactly F cycles: output at edge k+3+F.
- `encoder_trigger` is high for exactly one cycle. Minimum spacing is one valid step period, i.e. ≥ F+1 cycles.
- `N_encoder` and `enable` are sampled in the same cycle the step is applied; no extra latency.
- Input change rate is limited to one quadrature state per F+1 cycles; faster edges are filtered out, not errored.

## Structure
- Package `encoder_pkg`:
  - step enum {STEP_NONE, STEP_FWD, STEP_REV, STEP_ERR}.
  - Gray next-state constants for the forward sequence.
  - Default POS_W.
- Sub-module `quad_input_filter`: one channel of 2-flop sync plus run-length filter. Parameter FILTER_LEN; ports `clk`, `reset`, `load`, `din`, `dout`. Instantiated twice.
- Top level holds the arming counter, decoder, position, pitch logic, and `trigger_count`.

## Test plan
- Forward sweep: FILTER_LEN=0, N_encoder=160, 480 forward steps at 4-cycle spacing → pulses after steps 160, 320, 480; `trigger_count`=3; `position`=480; each pulse at edge k+3.
- Backlash: N=10, 25 forward steps, 7 reverse, 12 forward → pulses after forward steps 10, 20, 37 (not 30); `position`=30.
- Glitch: FILTER_LEN=4, 3-cycle pulse on `enc_a` → no step; 5-cycle stable change → one step at edge k+7.
- Illegal transition: 00→11 → `quad_error`=1 and stays 1; `position` unchanged; subsequent 11→10 counts +1.
- Enable/N edge cases: `enable`=0 across a pitch boundary → no pulse and `trigger_count` unchanged, but `acc` wraps. N=0 → no pulses. N changed from 160 to 5 while `acc`=40 → pulse on the next debt-free forward step.
- Reset: reset mid-sweep while `enc_a`/`enc_b`=11 → all outputs 0, no spurious step at arming, counting resumes correctly.
